ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter AW, default 5, RAM address width (32 entries).
REQ-002 Parameter DW, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 a_req  input  1  requester A transaction request, held until a_ack.
REQ-006 a_we  input  1  requester A: 1 = write, 0 = read.
REQ-007 a_addr  input  AW  requester A address.
REQ-008 a_wdata  input  DW  requester A write data.
REQ-009 a_ack  output  1  one-cycle completion pulse to A.
REQ-010 a_rdata  output  DW  read data to A, valid while a_ack=1, then held.
REQ-011 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: requester B ports, same widths and meaning as A.
REQ-012 ram_addr  output  AW  RAM address.
REQ-013 ram_din  output  DW  RAM write data.
REQ-014 ram_we  output  1  RAM write strobe.
REQ-015 ram_dout  input  DW  RAM synchronous read data, valid the cycle after the address is presented.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 All outputs shall be registered; states are IDLE, ISSUE, WAIT, ACK.
REQ-018 IDLE: if a_req or b_req is high, select a winner, latch its we/addr/wdata and identity, and go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE: ram_addr = latched addr; on a write, ram_din = latched wdata and ram_we = 1 for exactly this cycle, next ACK; on a read, ram_we = 0, next WAIT.
REQ-020 WAIT (read only): capture ram_dout into the winner's x_rdata at the end of the cycle, next ACK.
REQ-021 ACK: the winner's x_ack = 1 for exactly one cycle, the other ack = 0, next IDLE.
REQ-022 Latency from the IDLE cycle that samples req to ack: write 2 cycles, read 3 cycles; 1 IDLE bubble between back-to-back grants.
REQ-023 Requester input changes after the IDLE grant cycle shall not affect the current transaction.
REQ-024 A requester that still holds req in the IDLE cycle after its ack shall be treated as a new request.
REQ-025 The non-winning requester's x_rdata shall be unchanged by a transaction.
REQ-026 ram_we shall never be high outside ISSUE, and a_ack and b_ack shall never be high together.
REQ-027 Arbitration with a single requester: grant it immediately, regardless of the priority state.

Reset
REQ-028 On reset_n low, immediately and asynchronously: state = IDLE, ram_we = 0, ram_addr = 0, ram_din = 0, a_ack = b_ack = 0, a_rdata = b_rdata = 0, busy = 0, last-served pointer = B.
REQ-029 Reset mid-transaction shall abandon it with no ack; a write aborted before the ISSUE clock edge shall not write RAM.
REQ-030 The first posedge after reset_n rises shall be an IDLE arbitration cycle.

Configuration
REQ-031 Macro ARB_RR_EN defined: on simultaneous requests, grant the requester not served last; the last-served pointer updates on every grant.
REQ-032 Macro ARB_RR_EN undefined: fixed priority, A always wins simultaneous requests; the pointer logic is absent.

Verification
REQ-033 After reset, A writes addr 5 = 8'hA5 -> ram_we=1, ram_addr=5, ram_din=8'hA5 one cycle after the grant; a_ack pulses one cycle later.
REQ-034 B reads addr 5 with the RAM model returning 8'hA5 -> b_ack pulses 3 cycles after the sample with b_rdata=8'hA5; a_rdata unchanged.
REQ-035 A and B request together, both held for 4 transactions, ARB_RR_EN defined -> grants A,B,A,B; undefined -> all A grants while A holds req, B served only after A drops req.
REQ-036 A writes addr 31 = 8'hFF, then addr 0 = 8'h00 back-to-back -> two single-cycle ram_we pulses separated by 2 idle-strobe cycles, with no address wrap error.
REQ-037 Assert reset_n low during the ISSUE cycle of an A write -> ram_we drops asynchronously, no a_ack, busy=0; after release a new B read completes normally.
REQ-038 Change a_addr and a_wdata in the cycle after the grant -> RAM sees the originally latched values.

Source files
------------

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Two-requester arbiter in front of a single-port synchronous
//                RAM. One transaction is in flight at a time. It moves
//                through IDLE -> ISSUE -> (WAIT) -> ACK -> IDLE.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    AW        RAM address width (default 5 -> 32 entries)
//    DW        RAM data width    (default 8)
//  Ports
//    clk       single clock, rising-edge active
//    reset_n   asynchronous active-low reset
//    a_req     A request, held by A until a_ack
//    a_we      A direction: 1 = write, 0 = read
//    a_addr    A address
//    a_wdata   A write data
//    a_ack     one-cycle completion pulse to A
//    a_rdata   read data to A, valid with a_ack and held afterwards
//    b_*       requester B, same meaning as the A ports
//    ram_addr  RAM address
//    ram_din   RAM write data
//    ram_we    RAM write strobe (only ever high in ISSUE)
//    ram_dout  RAM read data, valid the cycle after the address
//    busy      high whenever the arbiter is not in IDLE
//  Configuration
//    ARB_RR_EN  defined   : round-robin on simultaneous requests
//               undefined : fixed priority, A wins simultaneous requests
// ============================================================================
module ram_port_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    // requester A
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    // requester B
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    // RAM side
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    // status
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t r_state;

    // Transaction context latched at the grant. After the grant the
    // requester inputs are not looked at again until the next IDLE cycle.
    logic r_we;     // latched direction of the current transaction
    logic r_sel_b;  // 1 = B owns the current transaction, 0 = A

`ifdef ARB_RR_EN
    // Last-served pointer. 1 = B was served last. It resets to B, so the
    // first contested grant after reset goes to A.
    logic r_last_b;
`endif

    // ------------------------------------------------------------------
    // Winner selection (combinational, only used in IDLE)
    // ------------------------------------------------------------------
    logic          w_grant_b;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    always_comb begin
        w_grant_b = 1'b0;
        if (b_req && !a_req) begin
            // A lone requester is granted whatever the priority state is.
            w_grant_b = 1'b1;
        end else if (a_req && b_req) begin
`ifdef ARB_RR_EN
            // Contested: serve whoever was not served last.
            w_grant_b = ~r_last_b;
`else
            w_grant_b = 1'b0;
`endif
        end
    end

    assign w_we    = w_grant_b ? b_we    : a_we;
    assign w_addr  = w_grant_b ? b_addr  : a_addr;
    assign w_wdata = w_grant_b ? b_wdata : a_wdata;

    // ------------------------------------------------------------------
    // Sequencer. All outputs are registered here.
    // ram_addr and ram_din are loaded at the grant, so they are already
    // stable during the ISSUE cycle. ram_we is raised at the same edge,
    // only for a write, and cleared at the end of ISSUE. That gives a
    // single-cycle strobe that cannot appear in any other state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_sel_b  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            busy     <= 1'b0;
`ifdef ARB_RR_EN
            r_last_b <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    if (a_req || b_req) begin
                        r_state  <= S_ISSUE;
                        busy     <= 1'b1;
                        r_sel_b  <= w_grant_b;
                        r_we     <= w_we;
                        ram_addr <= w_addr;
                        ram_we   <= w_we;
                        // Write data only needs to be valid for a write.
                        // Leave ram_din alone on reads so it does not toggle.
                        if (w_we) begin
                            ram_din <= w_wdata;
                        end
`ifdef ARB_RR_EN
                        r_last_b <= w_grant_b;
`endif
                    end
                end

                S_ISSUE: begin
                    ram_we <= 1'b0;
                    if (r_we) begin
                        // The write is committed at this edge, so acknowledge next.
                        r_state <= S_ACK;
                        a_ack   <= ~r_sel_b;
                        b_ack   <= r_sel_b;
                    end else begin
                        // The RAM registers the address at this edge. Its
                        // data appears during WAIT.
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // Only the winner's read-data register is loaded. The
                    // other requester keeps its last value.
                    if (r_sel_b) begin
                        b_rdata <= ram_dout;
                    end else begin
                        a_rdata <= ram_dout;
                    end
                    r_state <= S_ACK;
                    a_ack   <= ~r_sel_b;
                    b_ack   <= r_sel_b;
                end

                S_ACK: begin
                    // Ack drops after one cycle. The next IDLE cycle always
                    // re-arbitrates. A requester still holding req there
                    // counts as a fresh request.
                    r_state <= S_IDLE;
                    a_ack   <= 1'b0;
                    b_ack   <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    ram_we  <= 1'b0;
                    a_ack   <= 1'b0;
                    b_ack   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Directed self-checking bench for ram_port_arbiter with a
//                32x8 synchronous RAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          busy;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ack    (a_ack),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .b_rdata  (b_rdata),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model with a one-cycle read latency. Every entry
    // starts as 8'h11, so writing 8'h00 and untouched entries can both be
    // observed.
    logic [DW-1:0] mem [32];
    logic          mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h11;
            ram_dout <= 8'h00;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits up to 12 cycles for an ack. who: 0 = A, 1 = B, -1 = none.
    // cyc is the number of edges that passed before the ack was seen.
    task automatic wait_ack(output int who, output int cyc);
        bit done;
        who  = -1;
        cyc  = 0;
        done = 0;
        for (int i = 1; i <= 12 && !done; i++) begin
            tick();
            if (a_ack === 1'b1 || b_ack === 1'b1) begin
                check("ack_exclusive", 32'(a_ack & b_ack), 32'd0);
                who  = (b_ack === 1'b1) ? 1 : 0;
                cyc  = i;
                done = 1;
            end
        end
        check("ack_seen", (who < 0) ? 32'd0 : 32'd1, 32'd1);
    endtask

    int who, cyc;
`ifdef ARB_RR_EN
    int exp_w [4] = '{0, 1, 0, 1};
`else
    int exp_w [4] = '{0, 0, 0, 0};
`endif

    initial begin
        reset_n   = 1'b0;
        mem_clear = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_ram_we",   32'(ram_we),   32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din",  32'(ram_din),  32'd0);
        check("rst_acks",     32'({a_ack, b_ack}), 32'd0);
        check("rst_rdata",    32'({a_rdata, b_rdata}), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        mem_clear = 1'b0;
        reset_n   = 1'b1;

        // ---------------- A write 5 = A5, inputs changed after grant ----
        a_req = 1; a_we = 1; a_addr = 5'd5; a_wdata = 8'hA5;
        tick();                                  // ISSUE
        check("wr_issue_we",   32'(ram_we),   32'd1);
        check("wr_issue_addr", 32'(ram_addr), 32'd5);
        check("wr_issue_din",  32'(ram_din),  32'hA5);
        check("wr_issue_busy", 32'(busy),     32'd1);
        check("wr_issue_ack",  32'(a_ack),    32'd0);
        a_addr = 5'd9; a_wdata = 8'h33;          // must not affect this write
        tick();                                  // ACK
        check("wr_ack_a",    32'(a_ack),  32'd1);
        check("wr_ack_b",    32'(b_ack),  32'd0);
        check("wr_ack_we",   32'(ram_we), 32'd0);
        check("wr_mem5",     32'(mem[5]), 32'hA5);
        check("wr_mem9",     32'(mem[9]), 32'h11);
        a_req = 0;
        tick();                                  // IDLE
        check("wr_idle_ack",  32'(a_ack), 32'd0);
        check("wr_idle_busy", 32'(busy),  32'd0);

        // ---------------- B read 5 ----------------
        b_req = 1; b_we = 0; b_addr = 5'd5;
        tick();                                  // ISSUE
        check("rd_issue_we",   32'(ram_we),   32'd0);
        check("rd_issue_addr", 32'(ram_addr), 32'd5);
        tick();                                  // WAIT
        check("rd_wait_ack",   32'(b_ack),    32'd0);
        tick();                                  // ACK
        check("rd_ack_b",      32'(b_ack),    32'd1);
        check("rd_b_rdata",    32'(b_rdata),  32'hA5);
        check("rd_a_rdata",    32'(a_rdata),  32'h00);
        b_req = 0;
        tick();                                  // IDLE
        check("rd_idle_ack",   32'(b_ack),    32'd0);
        check("rd_rdata_held", 32'(b_rdata),  32'hA5);

        // ---------------- simultaneous held requests ----------------
        a_req = 1; a_we = 0; a_addr = 5'd5;
        b_req = 1; b_we = 0; b_addr = 5'd5;
        for (int t = 0; t < 4; t++) begin
            wait_ack(who, cyc);
            check("arb_winner", 32'(who), 32'(exp_w[t]));
            // The first wait starts in IDLE. Later waits start in ACK and
            // therefore include the single IDLE bubble.
            check("arb_latency", 32'(cyc), (t == 0) ? 32'd3 : 32'd4);
            if (t == 3) a_req = 0;
        end
        wait_ack(who, cyc);
        check("arb_b_after_a_drops", 32'(who), 32'd1);
        check("arb_a_rdata", 32'(a_rdata), 32'hA5);
        b_req = 0;
        tick();                                  // IDLE

        // ---------------- back-to-back writes at 31 and 0 ----------------
        a_req = 1; a_we = 1; a_addr = 5'd31; a_wdata = 8'hFF;
        tick();                                  // ISSUE
        check("b2b_we1",   32'(ram_we),   32'd1);
        check("b2b_addr1", 32'(ram_addr), 32'd31);
        check("b2b_din1",  32'(ram_din),  32'hFF);
        a_addr = 5'd0; a_wdata = 8'h00;
        tick();                                  // ACK
        check("b2b_gap1",  32'({ram_we, a_ack}), 32'b01);
        tick();                                  // IDLE, req still held
        check("b2b_gap2",  32'({ram_we, busy}),  32'b00);
        tick();                                  // ISSUE
        check("b2b_we2",   32'(ram_we),   32'd1);
        check("b2b_addr2", 32'(ram_addr), 32'd0);
        check("b2b_din2",  32'(ram_din),  32'h00);
        tick();                                  // ACK
        check("b2b_ack2",  32'({ram_we, a_ack}), 32'b01);
        a_req = 0;
        tick();                                  // IDLE
        check("b2b_mem31", 32'(mem[31]), 32'hFF);
        check("b2b_mem0",  32'(mem[0]),  32'h00);

        // ---------------- reset during ISSUE of an A write ----------------
        a_req = 1; a_we = 1; a_addr = 5'd7; a_wdata = 8'h77;
        tick();                                  // ISSUE
        check("abort_issue_we", 32'(ram_we), 32'd1);
        a_req = 0;
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_we_async",   32'(ram_we),   32'd0);
        check("abort_busy_async", 32'(busy),     32'd0);
        check("abort_addr_async", 32'(ram_addr), 32'd0);
        tick();                                  // edge while still in reset
        check("abort_no_ack",  32'({a_ack, b_ack}), 32'd0);
        check("abort_mem7",    32'(mem[7]),  32'h11);
        check("abort_b_rdata", 32'(b_rdata), 32'h00);
        reset_n = 1'b1;
        b_req = 1; b_we = 0; b_addr = 5'd5;
        wait_ack(who, cyc);
        check("post_rst_winner",  32'(who),     32'd1);
        check("post_rst_latency", 32'(cyc),     32'd3);
        check("post_rst_b_rdata", 32'(b_rdata), 32'hA5);
        check("post_rst_a_rdata", 32'(a_rdata), 32'h00);
        b_req = 0;
        tick();
        check("post_rst_idle", 32'({b_ack, busy}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
